// File: rtl/fifo_rd_unpack_if.sv
// Handshake bundle between a FIFO read port, the unpacker, and the narrow beat sink.
// The master modport is the unpacker side; the slave modport is the surrounding environment.
interface fifo_rd_unpack_if #(
    parameter int DW = 32,
    parameter int OW = 8
);
    logic          r_req;
    logic          unempty;
    logic [DW-1:0] data_i;
    logic          o_valid;
    logic          o_ready;
    logic [OW-1:0] o_data;
    logic          o_last;
    logic          flush;
    logic          busy;

    modport master (
        output r_req,
        input  unempty,
        input  data_i,
        output o_valid,
        input  o_ready,
        output o_data,
        output o_last,
        input  flush,
        output busy
    );

    modport slave (
        input  r_req,
        output unempty,
        output data_i,
        input  o_valid,
        output o_ready,
        input  o_data,
        input  o_last,
        output flush,
        input  busy
    );
endinterface

// File: rtl/fifo_rd_unpack.sv
// Reads DW-bit words from a show-ahead FIFO and emits them as DW/OW beats of OW bits,
// prefetching the next word on the last beat so consecutive words stream without bubbles.
module fifo_rd_unpack #(
    parameter int DW        = 32,
    parameter int OW        = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_unpack_if.master  bus
);
    localparam int NB = DW / OW;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e                held_r, held_d;
    logic [CW-1:0]         cnt_r, cnt_d;
    logic [DW-1:0]         wd_r, wd_d;

    logic                  valid;
    logic                  last;
    logic                  xfer;
    logic                  req;
    logic                  pop;
    logic [CW-1:0]         beat_idx;
    logic [NB-1:0][OW-1:0] beats;

    assign beats = wd_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the word register is reset too, because o_data must read zero while in reset.
            held_r <= EMPTY;
            cnt_r  <= '0;
            wd_r   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            held_r <= held_d;
            cnt_r  <= cnt_d;
            wd_r   <= wd_d;
        end
    end

    // Next-state logic; flush overrides everything and leaves the word itself untouched.
    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of inferred latches.
        held_d = held_r;
        cnt_d  = cnt_r;
        wd_d   = wd_r;
        if (bus.flush) begin
            held_d = EMPTY;
            cnt_d  = '0;
        end else if (pop) begin
            held_d = HOLD;
            cnt_d  = '0;
            wd_d   = bus.data_i;
        end else if (xfer) begin
            if (last) begin
                held_d = EMPTY;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_r + 1'b1;
            end
        end
    end

    // Output logic; the read request prefetches while the final beat is being accepted.
    always_comb begin
        valid    = (held_r == HOLD) & ~bus.flush;
        last     = (cnt_r == CW'(NB - 1));
        xfer     = valid & bus.o_ready;
        req      = ~bus.flush & ((held_r == EMPTY) | (xfer & last));
        pop      = req & bus.unempty;
        beat_idx = (LSB_FIRST != 0) ? cnt_r : (CW'(NB - 1) - cnt_r);

        bus.r_req   = req;
        bus.o_valid = valid;
        bus.o_last  = last;
        bus.o_data  = beats[beat_idx];
        bus.busy    = (held_r == HOLD);
    end
endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Directed bench for fifo_rd_unpack: an LSB-first and an MSB-first instance share one FIFO model.
// Each cycle's beat is checked as the tuple {o_valid, o_last, o_data} with last/data masked when idle.
module tb_fifo_rd_unpack;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_rd_unpack_if #(.DW(32), .OW(8)) u0 ();
    fifo_rd_unpack_if #(.DW(32), .OW(8)) u1 ();

    assign u1.unempty = u0.unempty;
    assign u1.data_i  = u0.data_i;
    assign u1.o_ready = u0.o_ready;
    assign u1.flush   = u0.flush;

    fifo_rd_unpack #(.DW(32), .OW(8), .LSB_FIRST(1)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (u0.master)
    );

    fifo_rd_unpack #(.DW(32), .OW(8), .LSB_FIRST(0)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (u1.master)
    );

    logic [31:0] fq[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic drive_fifo();
        u0.unempty = (fq.size() != 0);
        u0.data_i  = (fq.size() != 0) ? fq[0] : 32'h0;
    endtask

    // Advance one clock; the FIFO model pops when the pre-edge request met a non-empty FIFO.
    task automatic tick();
        logic p;
        p = u0.r_req & u0.unempty;
        @(posedge clk);
        #1;
        if (p) void'(fq.pop_front());
        drive_fifo();
    endtask

    function automatic logic [9:0] beat0();
        return {u0.o_valid, u0.o_valid ? {u0.o_last, u0.o_data} : 9'h0};
    endfunction

    function automatic logic [9:0] beat1();
        return {u1.o_valid, u1.o_valid ? {u1.o_last, u1.o_data} : 9'h0};
    endfunction

    task automatic test_reset();
        rst        = 1'b0;
        u0.o_ready = 1'b0;
        u0.flush   = 1'b0;
        drive_fifo();
        #2;
        n_cmp++;
        if ({u0.o_valid, u0.o_last, u0.o_data, u0.busy} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_lsb: got %h expected %h", {u0.o_valid, u0.o_last, u0.o_data, u0.busy}, 11'h0);
        end
        n_cmp++;
        if ({u1.o_valid, u1.o_last, u1.o_data, u1.busy} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_msb: got %h expected %h", {u1.o_valid, u1.o_last, u1.o_data, u1.busy}, 11'h0);
        end
        n_cmp++;
        if (u0.r_req !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rreq: got %b expected 1", u0.r_req);
        end
        u0.flush = 1'b1;
        #1;
        n_cmp++;
        if (u0.r_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rreq_flush: got %b expected 0", u0.r_req);
        end
        u0.flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_fifo();
    endtask

    task automatic test_single_word();
        logic [9:0] exp [6] = '{10'h000, 10'h211, 10'h222, 10'h233, 10'h344, 10'h000};
        fq.push_back(32'h44332211);
        u0.o_ready = 1'b1;
        drive_fifo();
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (beat0() !== exp[c]) begin
                n_err++;
                $display("FAIL single c%0d: got %h expected %h", c, beat0(), exp[c]);
            end
            if (c == 0 || c == 4) begin
                n_cmp++;
                if (u0.r_req !== 1'b1) begin
                    n_err++;
                    $display("FAIL single_rreq c%0d: got %b expected 1", c, u0.r_req);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [10] = '{10'h000, 10'h211, 10'h222, 10'h233, 10'h344,
                                 10'h255, 10'h266, 10'h277, 10'h388, 10'h000};
        fq.push_back(32'h44332211);
        fq.push_back(32'h88776655);
        u0.o_ready = 1'b1;
        drive_fifo();
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if (beat0() !== exp[c]) begin
                n_err++;
                $display("FAIL b2b c%0d: got %h expected %h", c, beat0(), exp[c]);
            end
            if (c == 4) begin
                n_cmp++;
                if ({u0.r_req, u0.unempty} !== 2'b11) begin
                    n_err++;
                    $display("FAIL b2b_pop c4: got %b expected 11", {u0.r_req, u0.unempty});
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic       rdy [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [9:0] exp [8] = '{10'h000, 10'h211, 10'h222, 10'h222, 10'h222, 10'h233, 10'h344, 10'h000};
        fq.push_back(32'h44332211);
        drive_fifo();
        for (int c = 0; c < 8; c++) begin
            u0.o_ready = rdy[c];
            #1;
            n_cmp++;
            if (beat0() !== exp[c]) begin
                n_err++;
                $display("FAIL backpressure c%0d: got %h expected %h", c, beat0(), exp[c]);
            end
            tick();
        end
        u0.o_ready = 1'b1;
    endtask

    task automatic test_flush();
        logic [9:0] exp [9] = '{10'h000, 10'h211, 10'h000, 10'h000, 10'h2AA,
                                10'h2BB, 10'h2CC, 10'h3DD, 10'h000};
        fq.push_back(32'h44332211);
        u0.o_ready = 1'b1;
        drive_fifo();
        for (int c = 0; c < 9; c++) begin
            u0.flush = (c == 2);
            if (c == 2) begin
                fq.push_back(32'hDDCCBBAA);
                drive_fifo();
            end
            #1;
            n_cmp++;
            if (beat0() !== exp[c]) begin
                n_err++;
                $display("FAIL flush c%0d: got %h expected %h", c, beat0(), exp[c]);
            end
            if (c == 2) begin
                n_cmp++;
                if (u0.r_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL flush_rreq c2: got %b expected 0", u0.r_req);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({u0.busy, u0.r_req} !== 2'b01) begin
                    n_err++;
                    $display("FAIL flush_busy c3: got %b expected 01", {u0.busy, u0.r_req});
                end
            end
            tick();
        end
        u0.flush = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [9:0] exp_a [4] = '{10'h000, 10'h211, 10'h222, 10'h233};
        logic [9:0] exp_b [6] = '{10'h000, 10'h209, 10'h20A, 10'h20B, 10'h30C, 10'h000};
        fq.push_back(32'h44332211);
        u0.o_ready = 1'b1;
        drive_fifo();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (beat0() !== exp_a[c]) begin
                n_err++;
                $display("FAIL areset_pre c%0d: got %h expected %h", c, beat0(), exp_a[c]);
            end
            if (c < 3) tick();
        end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({u0.o_valid, u0.busy, u0.o_data} !== 10'h0) begin
            n_err++;
            $display("FAIL areset_mid: got %h expected %h", {u0.o_valid, u0.busy, u0.o_data}, 10'h0);
        end
        tick();
        rst = 1'b1;
        fq.push_back(32'h0C0B0A09);
        drive_fifo();
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (beat0() !== exp_b[c]) begin
                n_err++;
                $display("FAIL areset_post c%0d: got %h expected %h", c, beat0(), exp_b[c]);
            end
            tick();
        end
    endtask

    task automatic test_msb_first();
        logic [9:0] exp [6] = '{10'h000, 10'h244, 10'h233, 10'h222, 10'h311, 10'h000};
        fq.push_back(32'h44332211);
        u0.o_ready = 1'b1;
        drive_fifo();
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (beat1() !== exp[c]) begin
                n_err++;
                $display("FAIL msb_first c%0d: got %h expected %h", c, beat1(), exp[c]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_msb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_rd_unpack.md
FIFO_RD_UNPACK -- requirements
Module: fifo_rd_unpack

Interface
REQ-001 SHALL have parameter DW, default 32: width of the FIFO word read in.
REQ-002 SHALL have parameter OW, default 8: width of each output beat; DW SHALL be an integer multiple of OW.
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 emits the low OW bits first; 0 emits the high OW bits first.
REQ-004 SHALL have port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port r_req, output, 1: read request to the FIFO read port.
REQ-007 SHALL have port unempty, input, 1: FIFO holds at least one word.
REQ-008 SHALL have port data_i, input, DW: FIFO head word, valid combinationally while unempty=1.
REQ-009 SHALL have port o_valid, output, 1: output beat valid.
REQ-010 SHALL have port o_ready, input, 1: downstream accepts the beat.
REQ-011 SHALL have port o_data, output, OW: output beat.
REQ-012 SHALL have port o_last, output, 1: the current beat is the final beat of its word.
REQ-013 SHALL have port flush, input, 1: synchronous discard of the held word.
REQ-014 SHALL have port busy, output, 1: a word is held (held_r).

Function
REQ-015 SHALL define NB = DW/OW and a beat counter cnt of width max(1, clog2(NB)).
REQ-016 SHALL have two states: EMPTY (held_r=0) and HOLD (held_r=1). The state register is held_r, with a DW-bit word register wd_r.
REQ-017 SHALL define a FIFO pop as pop = r_req & unempty.
REQ-018 SHALL drive r_req = ~flush & (~held_r | (o_valid & o_ready & o_last)), a prefetch on the last beat.
REQ-019 SHALL load wd_r <= data_i, set held_r <= 1 and set cnt <= 0 on a pop.
REQ-020 SHALL give one-cycle latency: a pop in cycle N yields o_valid=1 with beat 0 in cycle N+1.
REQ-021 SHALL drive o_valid = held_r & ~flush.
REQ-022 SHALL define a transfer as o_valid & o_ready; each transfer with o_last=0 SHALL increment cnt.
REQ-023 SHALL drive o_last = (cnt == NB-1).
REQ-024 SHALL, on a transfer with o_last=1 and no pop in the same cycle, clear held_r and cnt (HOLD -> EMPTY).
REQ-025 SHALL, on a transfer with o_last=1 and a pop in the same cycle, stay in HOLD and reload per REQ-019, giving zero-bubble word boundaries.
REQ-026 SHALL select o_data as follows:
- LSB_FIRST=1: o_data = wd_r[cnt*OW +: OW].
- LSB_FIRST=0: o_data = wd_r[(NB-1-cnt)*OW +: OW].
REQ-027 SHALL hold o_data, o_last and cnt stable while o_valid=1 and o_ready=0.
REQ-028 SHALL, when NB=1, emit each word as a single beat with o_last=1 constantly.
REQ-029 SHALL, while flush=1, block any pop or transfer, clear held_r and cnt at the next edge, and keep wd_r unchanged.
REQ-030 SHALL sustain one beat per cycle when unempty=1 and o_ready=1 continuously.
REQ-031 SHALL keep unempty=0 in HOLD from affecting emission of the remaining beats of the held word.

Reset
REQ-032 SHALL, while rst=0, asynchronously clear held_r=0, cnt=0 and wd_r=0, giving o_valid=0, o_last=0 (NB>1), o_data=0 and busy=0.
REQ-033 SHALL leave r_req combinational per REQ-018 after rst deasserts; in EMPTY it equals ~flush.
REQ-034 SHALL, on reset mid-word, lose the held word; the first pop after reset starts again at beat 0.

Verification (DW=32, OW=8, LSB_FIRST=1 unless stated)
REQ-035 SHALL cover single word: FIFO holds 0x44332211, o_ready=1 -> pop in cycle 0; o_data 11,22,33,44 in cycles 1-4; o_last=1 only in cycle 4; o_valid=0 in cycle 5.
REQ-036 SHALL cover back-to-back words: FIFO holds 0x44332211 then 0x88776655, o_ready=1 -> 8 consecutive beats 11..88 in cycles 1-8; second pop in cycle 4; no bubble.
REQ-037 SHALL cover backpressure: o_ready=0 in cycles 2-3 of REQ-035 -> o_data=0x22, o_valid=1 stable in cycles 2-4; beat 44 in cycle 6.
REQ-038 SHALL cover flush: flush=1 in cycle 2 of REQ-035 -> o_valid=0 and r_req=0 in cycle 2; busy=0 in cycle 3; next word 0xDDCCBBAA emits AA first.
REQ-039 SHALL cover async reset: rst=0 mid-cycle 3 of REQ-035 -> o_valid=0 and busy=0 immediately; after release, a new pop emits beat 0.
REQ-040 SHALL cover MSB-first: LSB_FIRST=0 with word 0x44332211 -> o_data 44,33,22,11, o_last on 11.
